// File: rtl/ysyx_22050019_fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory and decode.
// master = fetch queue side, slave = memory/decode side.
interface ysyx_22050019_fetch_queue_if #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst
    );
endinterface

// File: rtl/ysyx_22050019_fetch_queue.sv
// Prefetch queue: in-order imem requests into a DEPTH-slot ring, flushed on redirect.
// Responses for requests issued before a redirect are counted in drop_cnt and discarded.
module ysyx_22050019_fetch_queue #(
    parameter int              ADDR_W   = 64,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h80000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    ysyx_22050019_fetch_queue_if.master  bus,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] slot_pc     [DEPTH];
    logic [INST_W-1:0] slot_inst   [DEPTH];
    logic [DEPTH-1:0]  slot_filled;

    logic [PTR_W:0]    alloc_ptr, fill_ptr, head_ptr;
    logic [CNT_W-1:0]  drop_cnt;
    logic [ADDR_W-1:0] fpc;
    logic              run;

    logic [PTR_W-1:0]  alloc_idx, fill_idx, head_idx;
    logic              empty;
    logic [CNT_W:0]    credits_used;
    logic [PTR_W:0]    inflight;
    logic              req_fire, rsp_fill, pop;

    assign alloc_idx = alloc_ptr[PTR_W-1:0];
    assign fill_idx  = fill_ptr[PTR_W-1:0];
    assign head_idx  = head_ptr[PTR_W-1:0];

    // Same index with same wrap bit means nothing allocated.
    assign empty = (alloc_idx == head_idx) && (alloc_ptr[PTR_W] == head_ptr[PTR_W]);

    assign count        = CNT_W'(alloc_ptr - head_ptr);
    assign inflight     = alloc_ptr - fill_ptr;
    assign credits_used = {1'b0, count} + {1'b0, drop_cnt};

    assign bus.imem_req_valid = run && !bus.redirect_valid && (credits_used < (CNT_W+1)'(DEPTH));
    assign bus.imem_req_addr  = fpc;

    assign bus.out_valid = slot_filled[head_idx] && !empty;
    assign bus.out_pc    = slot_pc[head_idx];
    assign bus.out_inst  = slot_inst[head_idx];

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_fill = bus.imem_rsp_valid && (drop_cnt == '0);
    assign pop      = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc         <= RESET_PC;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            head_ptr    <= '0;
            drop_cnt    <= '0;
            run         <= 1'b0;
            slot_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc[i]   <= '0;
                slot_inst[i] <= '0;
            end
        end else begin
            run <= 1'b1;
            if (bus.redirect_valid) begin
                // Everything still in flight becomes stale, including a response landing now.
                alloc_ptr   <= '0;
                fill_ptr    <= '0;
                head_ptr    <= '0;
                slot_filled <= '0;
                fpc         <= bus.redirect_pc & ~ADDR_W'(3);
                drop_cnt    <= drop_cnt + CNT_W'(inflight) - CNT_W'(bus.imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    slot_pc[alloc_idx]     <= fpc;
                    slot_filled[alloc_idx] <= 1'b0;
                    alloc_ptr              <= alloc_ptr + 1'b1;
                    fpc                    <= fpc + ADDR_W'(4);
                end
                if (bus.imem_rsp_valid && drop_cnt != '0)
                    drop_cnt <= drop_cnt - 1'b1;
                if (rsp_fill) begin
                    slot_inst[fill_idx]   <= bus.imem_rsp_data;
                    slot_filled[fill_idx] <= 1'b1;
                    fill_ptr              <= fill_ptr + 1'b1;
                end
                if (pop) begin
                    slot_filled[head_idx] <= 1'b0;
                    head_ptr              <= head_ptr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22050019_fetch_queue.sv
// Randomized bench: driver feeds an in-order memory model; a negedge monitor
// compares the DUT against a queue-level model of the expected instruction stream.
module tb_ysyx_22050019_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h80000000;

    logic       clk, rst_n;
    logic [2:0] count;

    ysyx_22050019_fetch_queue_if #(.ADDR_W(64), .INST_W(32)) bus ();

    ysyx_22050019_fetch_queue #(.ADDR_W(64), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [63:0] pc; logic [31:0] inst; bit filled; } exp_t;
    typedef struct { logic [31:0] data; int epoch; int due; } mem_t;

    exp_t exp_q[$];
    mem_t mem_pend[$];

    int errors = 0, checks = 0;
    int cyc = 0, epoch = 0, rsp_epoch = 0, pop_cnt = 0;
    int issued = 0, responded = 0;
    int lat_min = 1, lat_max = 1;
    int p_rsp = 100, p_req_rdy = 100, p_out_rdy = 100, p_redir = 0;
    bit redir_now = 0;
    logic [63:0] redir_target;

    logic [63:0] m_fpc = RESET_PC;
    bit          run_m = 0;

    function automatic logic [31:0] mem_word(logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: checks current outputs, then applies this cycle's events.
    int  stale;
    bit  exp_ov, exp_rv, req_fire, popped, marked;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            mem_pend.delete();
            m_fpc = RESET_PC;
            run_m = 0;
            epoch++;
            issued = 0;
            responded = 0;
        end else begin
            stale = 0;
            foreach (mem_pend[i]) if (mem_pend[i].epoch != epoch) stale++;
            if (bus.imem_rsp_valid && rsp_epoch != epoch) stale++;
            exp_ov = (exp_q.size() > 0) && exp_q[0].filled;
            exp_rv = run_m && !bus.redirect_valid && (exp_q.size() + stale < DEPTH);
            chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
            chk("count", 64'(count), 64'(exp_q.size()));
            chk("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
            if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, m_fpc);
            if (bus.imem_rsp_valid) begin
                assert (responded < issued) else $error("response with no outstanding request");
                responded++;
            end

            req_fire = bus.imem_req_valid && bus.imem_req_ready;
            popped   = bus.out_valid && bus.out_ready;
            if (popped && exp_ov) begin
                chk("out_pc", bus.out_pc, exp_q[0].pc);
                chk("out_inst", 64'(bus.out_inst), 64'(exp_q[0].inst));
                pop_cnt++;
            end
            if (req_fire) begin
                mem_pend.push_back('{data: mem_word(bus.imem_req_addr),
                                     epoch: bus.redirect_valid ? -1 : epoch,
                                     due: cyc + $urandom_range(lat_max, lat_min)});
                issued++;
            end
            if (bus.redirect_valid) begin
                exp_q.delete();
                m_fpc = bus.redirect_pc & ~64'h3;
                epoch++;
            end else begin
                if (bus.imem_rsp_valid && rsp_epoch == epoch) begin
                    marked = 0;
                    foreach (exp_q[i]) if (!marked && !exp_q[i].filled) begin
                        exp_q[i].filled = 1;
                        marked = 1;
                    end
                end
                if (popped && exp_ov) void'(exp_q.pop_front());
                if (req_fire) begin
                    exp_q.push_back('{pc: m_fpc, inst: mem_word(m_fpc), filled: 0});
                    m_fpc = m_fpc + 64'd4;
                end
            end
            run_m = 1;
        end
    end

    // Driver: one call per clock, inputs change 1ns after the rising edge.
    task automatic step();
        mem_t m;
        @(posedge clk);
        #1;
        cyc++;
        if (mem_pend.size() > 0 && mem_pend[0].due <= cyc && $urandom_range(99) < p_rsp) begin
            m = mem_pend.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = m.data;
            rsp_epoch          = m.epoch;
        end else begin
            bus.imem_rsp_valid = 1'b0;
        end
        bus.imem_req_ready = ($urandom_range(99) < p_req_rdy);
        bus.out_ready      = ($urandom_range(99) < p_out_rdy);
        if (redir_now) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = redir_target;
            redir_now          = 0;
        end else begin
            bus.redirect_valid = ($urandom_range(99) < p_redir);
            bus.redirect_pc    = ($urandom_range(15) == 0) ? 64'hFFFF_FFFF_FFFF_FFF6
                                                           : {32'h0, 16'h8000, 16'($urandom)};
        end
    endtask

    task automatic run_cycles(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int p0;
    initial begin
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.out_ready      = 1'b0;
        #2;
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("rst count", 64'(count), 64'd0);
        chk("rst out_pc", bus.out_pc, 64'd0);
        chk("rst out_inst", 64'(bus.out_inst), 64'd0);
        run_cycles(2);
        rst_n = 1'b1;

        // Zero-wait memory, always-ready decode: one instruction per cycle after warm-up.
        run_cycles(20);
        p0 = pop_cnt;
        run_cycles(20);
        chk("throughput", 64'(pop_cnt - p0), 64'd20);

        // Decode stalled: queue fills to DEPTH and issue stops.
        p_out_rdy = 0;
        run_cycles(12);
        chk("full count", 64'(count), 64'(DEPTH));
        chk("full req_valid", 64'(bus.imem_req_valid), 64'd0);
        p_out_rdy = 100;
        run_cycles(10);

        // Slow memory with requests in flight, then redirect to a misaligned target.
        lat_min = 3; lat_max = 3;
        run_cycles(8);
        redir_now = 1; redir_target = 64'h80001002;
        run_cycles(20);

        // Memory refuses requests for 5 cycles.
        p_req_rdy = 0;
        run_cycles(5);
        p_req_rdy = 100;
        run_cycles(10);

        // Wrap-around of the fetch address.
        redir_now = 1; redir_target = 64'hFFFF_FFFF_FFFF_FFF8;
        run_cycles(15);

        // Random mix.
        lat_min = 1; lat_max = 4;
        p_rsp = 70; p_req_rdy = 70; p_out_rdy = 70; p_redir = 4;
        run_cycles(1500);

        // Asynchronous reset between edges with a stalled, full-ish queue.
        p_redir = 0; p_out_rdy = 0;
        run_cycles(8);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("async rst req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("async rst count", 64'(count), 64'd0);
        p_out_rdy = 70;
        step();
        rst_n = 1'b1;
        run_cycles(60);

        p_redir = 0; p_rsp = 100; p_out_rdy = 100;
        run_cycles(20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
